// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-channel sensor synchronizer and debouncer with glitch counter
module sensor_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e_raw,
    input  logic       w_raw,
    output logic       E,
    output logic       W,
    output logic       e_edge,
    output logic       w_edge,
    output logic [7:0] glitch_cnt
);

    typedef enum logic {STABLE, CHECK} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    // Index 0 is the east channel, index 1 the west channel.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       out_q;
    logic [1:0]       edge_q;
    logic [1:0]       glitch;
    state_t           state [2];
    logic [CNT_W-1:0] cnt   [2];
    logic [8:0]       gsum;

    assign raw = {w_raw, e_raw};

    always_comb begin
        glitch = '0;
        for (int i = 0; i < 2; i++) begin
            glitch[i] = (state[i] == CHECK) && (s2[i] == out_q[i]);
        end
    end

    assign gsum = {1'b0, glitch_cnt} + {8'd0, glitch[0]} + {8'd0, glitch[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            out_q      <= '0;
            edge_q     <= '0;
            glitch_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            s1     <= raw;
            s2     <= s1;
            edge_q <= '0;
            glitch_cnt <= gsum[8] ? 8'hFF : gsum[7:0];
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    STABLE: begin
                        if (s2[i] != out_q[i]) begin
                            state[i] <= CHECK;
                            cnt[i]   <= CNT_W'(1);
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    CHECK: begin
                        if (s2[i] == out_q[i]) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == LAST) begin
                            out_q[i]  <= ~out_q[i];
                            edge_q[i] <= 1'b1;
                            state[i]  <= STABLE;
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i]   <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign E      = out_q[0];
    assign W      = out_q[1];
    assign e_edge = edge_q[0];
    assign w_edge = edge_q[1];

endmodule

// File: tb/tb_sensor_debounce.sv
// tb/tb_sensor_debounce.sv - self-checking bench for sensor_debounce
module tb_sensor_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e_raw;
    logic       w_raw;
    logic       E;
    logic       W;
    logic       e_edge;
    logic       w_edge;
    logic [7:0] glitch_cnt;

    int vectors     = 0;
    int miscompares = 0;

    sensor_debounce dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_raw      (e_raw),
        .w_raw      (w_raw),
        .E          (E),
        .W          (W),
        .e_edge     (e_edge),
        .w_edge     (w_edge),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the last four synchronized samples all
    // differ from it; a glitch is a differing sample followed by a matching one.
    logic [1:0]  m_s1   = '0;
    logic [1:0]  m_s2   = '0;
    logic [1:0]  m_out  = '0;
    logic [1:0]  m_edge = '0;
    logic [3:0]  hist [2] = '{4'h0, 4'h0};
    int          m_g    = 0;
    logic [11:0] sb [$];

    always @(negedge rst_n) begin
        m_s1 = '0; m_s2 = '0; m_out = '0; m_edge = '0; m_g = 0;
        hist[0] = '0; hist[1] = '0;
        sb.delete();
    end

    always @(posedge clk) begin
        if (rst_n) begin
            int gl;
            gl = 0;
            for (int ch = 0; ch < 2; ch++) begin
                logic       cur;
                logic [3:0] nh;
                logic       tog;
                cur = m_s2[ch];
                nh  = {hist[ch][2:0], cur};
                tog = m_out[ch] ? (nh == 4'h0) : (nh == 4'hF);
                if ((hist[ch][0] != m_out[ch]) && (cur == m_out[ch])) gl++;
                hist[ch]   = nh;
                m_edge[ch] = tog;
                if (tog) m_out[ch] = ~m_out[ch];
            end
            m_g  = (m_g + gl > 255) ? 255 : m_g + gl;
            m_s2 = m_s1;
            m_s1 = {w_raw, e_raw};
        end
        sb.push_back({m_out[0], m_out[1], m_edge[0], m_edge[1], 8'(m_g)});
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [11:0] expv;
            logic [11:0] obs;
            expv = sb.pop_front();
            obs  = {E, W, e_edge, w_edge, glitch_cnt};
            vectors++;
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL scoreboard obs=%h exp=%h", obs, expv);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        e_raw = 1'b0;
        w_raw = 1'b0;

        // Reset held with raw inputs toggling
        for (int i = 0; i < 10; i++) begin
            e_raw = ~e_raw;
            w_raw = 1'($urandom_range(0, 1));
            cyc(1);
            chk("rst_outs", {4'd0, E, W, e_edge, w_edge}, 8'd0);
            chk("rst_gcnt", glitch_cnt, 8'd0);
        end
        e_raw = 1'b0;
        w_raw = 1'b0;
        rst_n = 1'b1;
        cyc(4);

        // East rise and fall, 6-edge latency each way
        e_raw = 1'b1;
        cyc(5);
        chk("e_rise_early", {7'd0, E}, 8'd0);
        cyc(1);
        chk("e_rise", {6'd0, E, e_edge}, 8'd3);
        cyc(1);
        chk("e_edge_once", {6'd0, E, e_edge}, 8'd2);
        cyc(3);
        e_raw = 1'b0;
        cyc(5);
        chk("e_fall_early", {7'd0, E}, 8'd1);
        cyc(1);
        chk("e_fall", {6'd0, E, e_edge}, 8'd1);
        cyc(1);
        chk("e_fall_edge_once", {7'd0, e_edge}, 8'd0);
        cyc(4);

        // Three-sample west pulse is rejected
        do_reset();
        w_raw = 1'b1;
        cyc(3);
        w_raw = 1'b0;
        cyc(8);
        chk("w_glitch_W", {7'd0, W}, 8'd0);
        chk("w_glitch_cnt", glitch_cnt, 8'd1);

        // Four-sample west pulse is accepted
        do_reset();
        w_raw = 1'b1;
        cyc(4);
        w_raw = 1'b0;
        cyc(2);
        chk("w_accept", {6'd0, W, w_edge}, 8'd3);
        cyc(10);
        chk("w_accept_cnt", glitch_cnt, 8'd0);
        chk("w_back_low", {7'd0, W}, 8'd0);

        // Simultaneous rise on both channels
        e_raw = 1'b1;
        w_raw = 1'b1;
        cyc(5);
        chk("both_early", {6'd0, E, W}, 8'd0);
        cyc(1);
        chk("both_rise", {4'd0, E, W, e_edge, w_edge}, 8'd15);
        cyc(3);

        // Asynchronous reset clears outputs mid-cycle
        rst_n = 1'b0;
        #1;
        chk("async_clear", {4'd0, E, W, e_edge, w_edge}, 8'd0);
        e_raw = 1'b0;
        w_raw = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Saturating glitch count with both channels glitching together
        for (int k = 0; k < 300; k++) begin
            e_raw = 1'b1;
            w_raw = 1'b1;
            cyc(3);
            e_raw = 1'b0;
            w_raw = 1'b0;
            cyc(5);
            chk("gcnt_step", glitch_cnt, 8'((2 * (k + 1) > 255) ? 255 : 2 * (k + 1)));
        end
        chk("gcnt_levels", {6'd0, E, W}, 8'd0);

        // Reset mid-check discards partial count
        do_reset();
        e_raw = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midchk_clear", {7'd0, E}, 8'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("midchk_early", {7'd0, E}, 8'd0);
        cyc(1);
        chk("midchk_rise", {6'd0, E, e_edge}, 8'd3);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
